// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the RV32M multiply/divide unit.
// Holds function encodings, FSM state enum, XLEN default, divide-by-zero quotient.
package muldiv_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] MD_MUL    = 3'd0;
   localparam logic [2:0] MD_MULH   = 3'd1;
   localparam logic [2:0] MD_MULHSU = 3'd2;
   localparam logic [2:0] MD_MULHU  = 3'd3;
   localparam logic [2:0] MD_DIV    = 3'd4;
   localparam logic [2:0] MD_DIVU   = 3'd5;
   localparam logic [2:0] MD_REM    = 3'd6;
   localparam logic [2:0] MD_REMU   = 3'd7;

   localparam logic [XLEN-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      FIX,
      DONE
   } md_state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: conditional two's-complement negate of a 2*XLEN value plus word select.
// Ports: val_i value, neg_i negate enable, hi_i select upper word, word_o selected word.
module muldiv_sign_fix
   import muldiv_pkg::*;
(
   input  logic [2*XLEN-1:0] val_i,
   input  logic              neg_i,
   input  logic              hi_i,
   output logic [XLEN-1:0]   word_o
);

   logic [2*XLEN-1:0] fixed;

   assign fixed  = neg_i ? (~val_i + 64'd1) : val_i;
   assign word_o = hi_i ? fixed[2*XLEN-1:XLEN] : fixed[XLEN-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 RV32M multiply/divide with req/resp valid/ready handshakes.
// Ports: clock, reset_n (async low), req_*, muldiv_function, op_a, op_b, flush,
// resp_*, result, busy. Optional MULDIV_EARLY_OUT_EN finishes trivial ops on accept.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      muldiv_function,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);
   import muldiv_pkg::*;

   md_state_e   state_q, state_d;
   logic [2:0]  func_q, func_d;
   logic [31:0] opnd_q, opnd_d;
   logic [63:0] acc_q, acc_d;
   logic        neg_q, neg_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] result_q, result_d;

   logic        in_div, a_sgn, b_sgn, a_neg, b_neg, b_zero, in_neg;
   logic [31:0] a_mag, b_mag, fix_word;
   logic [63:0] fix_val;
   logic        fix_hi;
   logic [32:0] mul_sum, div_tmp, div_diff;
   logic        div_ge;
   logic [63:0] mul_next, div_next;

   assign in_div = muldiv_function[2];
   assign a_sgn  = (muldiv_function == MD_MULH) || (muldiv_function == MD_MULHSU)
                || (muldiv_function == MD_DIV) || (muldiv_function == MD_REM);
   assign b_sgn  = (muldiv_function == MD_MULH) || (muldiv_function == MD_DIV)
                || (muldiv_function == MD_REM);
   assign a_neg  = a_sgn & op_a[31];
   assign b_neg  = b_sgn & op_b[31];
   assign b_zero = (op_b == 32'd0);

   // Divide by zero keeps the quotient positive so it lands on all-ones;
   // the remainder follows the dividend, which restores op_a.
   always_comb begin
      in_neg = a_neg ^ b_neg;
      if (in_div && muldiv_function[1]) begin
         in_neg = a_neg;
      end else if (in_div) begin
         in_neg = (a_neg ^ b_neg) && !b_zero;
      end
   end

   muldiv_sign_fix u_mag_a (
      .val_i  ({32'd0, op_a}),
      .neg_i  (a_neg),
      .hi_i   (1'b0),
      .word_o (a_mag)
   );

   muldiv_sign_fix u_mag_b (
      .val_i  ({32'd0, op_b}),
      .neg_i  (b_neg),
      .hi_i   (1'b0),
      .word_o (b_mag)
   );

   // Multiply: acc = {hi, multiplier}; add multiplicand into hi, shift right.
   assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
   assign mul_next = {mul_sum, acc_q[31:1]};

   // Divide: acc = {remainder, dividend/quotient}; restoring step.
   assign div_tmp  = {acc_q[63:32], acc_q[31]};
   assign div_ge   = (div_tmp >= {1'b0, opnd_q});
   assign div_diff = div_tmp - {1'b0, opnd_q};
   assign div_next = {div_ge ? div_diff[31:0] : div_tmp[31:0], acc_q[30:0], div_ge};

   assign fix_hi  = !func_q[2] && (func_q != MD_MUL);
   assign fix_val = !func_q[2] ? acc_q
                  : func_q[1] ? {32'd0, acc_q[63:32]}
                  : {32'd0, acc_q[31:0]};

   muldiv_sign_fix u_fix (
      .val_i  (fix_val),
      .neg_i  (neg_q),
      .hi_i   (fix_hi),
      .word_o (fix_word)
   );

`ifdef MULDIV_EARLY_OUT_EN
   logic        eo_hit;
   logic [31:0] eo_res;

   always_comb begin
      eo_hit = 1'b0;
      eo_res = 32'd0;
      if (in_div && b_zero) begin
         eo_hit = 1'b1;
         eo_res = muldiv_function[1] ? op_a : DIV0_QUOTIENT;
      end else if (((muldiv_function == MD_DIV) || (muldiv_function == MD_REM))
                   && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF)) begin
         eo_hit = 1'b1;
         eo_res = muldiv_function[1] ? 32'd0 : 32'h8000_0000;
      end else if (!in_div && ((op_a == 32'd0) || b_zero)) begin
         eo_hit = 1'b1;
         eo_res = 32'd0;
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      func_d   = func_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid && !flush) begin
               func_d  = muldiv_function;
               neg_d   = in_neg;
               cnt_d   = 5'd0;
               opnd_d  = in_div ? b_mag : a_mag;
               acc_d   = {32'd0, in_div ? a_mag : b_mag};
               state_d = ITER;
`ifdef MULDIV_EARLY_OUT_EN
               if (eo_hit) begin
                  result_d = eo_res;
                  state_d  = DONE;
               end
`endif
            end
         end
         ITER: begin
            acc_d = func_q[2] ? div_next : mul_next;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = FIX;
            end
         end
         FIX: begin
            result_d = fix_word;
            state_d  = DONE;
         end
         DONE: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush && (state_q != IDLE)) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         func_q   <= 3'd0;
         opnd_q   <= 32'd0;
         acc_q    <= 64'd0;
         neg_q    <= 1'b0;
         cnt_q    <= 5'd0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         func_q   <= func_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == DONE);
   assign busy       = (state_q != IDLE);
   assign result     = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
// Expected results go through a scoreboard queue; checks are immediate assertions.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  muldiv_function = 3'd0;
   logic [31:0] op_a = 32'd0;
   logic [31:0] op_b = 32'd0;
   logic        flush = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] result;
   logic        busy;

   int total = 0;
   int bad = 0;
   logic [31:0] exp_q[$];

   always #5 clock = ~clock;

   muldiv_unit #(.XLEN(32)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .muldiv_function (muldiv_function),
      .op_a            (op_a),
      .op_b            (op_b),
      .flush           (flush),
      .resp_valid      (resp_valid),
      .resp_ready      (resp_ready),
      .result          (result),
      .busy            (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s got=%h want=%h", tag, obs, expv);
      end
   endtask

   function automatic bit early(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      if (f[2] && b == 32'd0) return 1'b1;
      if ((f == MD_DIV || f == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
      if (!f[2] && (a == 32'd0 || b == 32'd0)) return 1'b1;
      return 1'b0;
`else
      return 1'b0;
`endif
   endfunction

   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expv, input int hold);
      int n;
      bit busy_ok;
      bit hold_ok;
      logic [31:0] held;
      @(negedge clock);
      muldiv_function = f;
      op_a = a;
      op_b = b;
      req_valid = 1'b1;
      exp_q.push_back(expv);
      chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      n = 0;
      busy_ok = 1'b1;
      while (!resp_valid && n < 100) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clock);
         #1;
         n++;
      end
      chk({tag, "_latency"}, 32'(n), early(f, a, b) ? 32'd0 : 32'd33);
      chk({tag, "_busy"}, {31'd0, busy_ok & busy}, 32'd1);
      chk({tag, "_result"}, result, exp_q.pop_front());
      if (hold > 0) begin
         held = result;
         hold_ok = 1'b1;
         muldiv_function = MD_MUL;
         op_a = 32'd2;
         op_b = 32'd3;
         req_valid = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            if (result !== held || req_ready !== 1'b0 || resp_valid !== 1'b1)
               hold_ok = 1'b0;
         end
         req_valid = 1'b0;
         chk({tag, "_hold"}, {31'd0, hold_ok}, 32'd1);
      end
      resp_ready = 1'b1;
      @(posedge clock);
      #1;
      resp_ready = 1'b0;
      chk({tag, "_idle"}, {29'd0, resp_valid, req_ready, busy}, 32'd2);
   endtask

   initial begin
      bit quiet;
      #1;
      chk("reset_state", {resp_valid, req_ready, busy, result[28:0]}, 32'h4000_0000);
      chk("reset_result", result, 32'd0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      run_op("mul_7x6",     MD_MUL,    32'd7,         32'd6,         32'h0000_002A, 0);
      run_op("mulh_m1m1",   MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
      run_op("mulhu_ff",    MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
      run_op("mulhsu_m1x2", MD_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 0);
      run_op("mulhu_64k",   MD_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 0);
      run_op("mul_zero",    MD_MUL,    32'd0,         32'd5,         32'h0000_0000, 0);
      run_op("div_m7_2",    MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
      run_op("rem_m7_2",    MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
      run_op("divu_big",    MD_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
      run_op("div_ovf",     MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
      run_op("rem_ovf",     MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
      run_op("divu_5_0",    MD_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 0);
      run_op("remu_5_0",    MD_REMU,   32'd5,         32'd0,         32'h0000_0005, 0);
      run_op("div_m5_0",    MD_DIV,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 0);
      run_op("rem_m5_0",    MD_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 0);
      run_op("divu_100_7",  MD_DIVU,   32'd100,       32'd7,         32'd14,        0);
      run_op("bp_mul",      MD_MUL,    32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 10);

      // flush once the iteration counter reads 15
      @(negedge clock);
      muldiv_function = MD_MUL;
      op_a = 32'd7;
      op_b = 32'd6;
      req_valid = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      repeat (15) @(posedge clock);
      #1;
      flush = 1'b1;
      @(posedge clock);
      #1;
      flush = 1'b0;
      chk("flush_idle", {29'd0, resp_valid, req_ready, busy}, 32'd2);
      quiet = 1'b1;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (resp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      end
      chk("flush_quiet", {31'd0, quiet}, 32'd1);

      // flush in IDLE blocks a simultaneous request
      @(negedge clock);
      req_valid = 1'b1;
      flush = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      flush = 1'b0;
      chk("flush_vs_req", {31'd0, busy}, 32'd0);

      // async reset in the middle of an iteration
      @(negedge clock);
      muldiv_function = MD_DIVU;
      op_a = 32'd1000;
      op_b = 32'd3;
      req_valid = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      repeat (10) @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_mid_flags", {29'd0, resp_valid, req_ready, busy}, 32'd2);
      chk("rst_mid_result", result, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      run_op("mul_3x3", MD_MUL, 32'd3, 32'd3, 32'd9, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide responder for the RV32M extension.
- Sits beside the single-cycle ALU in the execute stage and takes the same op_a/op_b operands.
- The execute stage issues requests on a valid/ready handshake; the unit returns one result per request on a second valid/ready handshake.
- Radix-2: 32 iteration cycles per operation.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clock  input  1  sole clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- muldiv_function  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- op_a  input  XLEN  rs1 value (multiplicand/dividend)
- op_b  input  XLEN  rs2 value (multiplier/divisor)
- flush  input  1  abort in-flight operation (pipeline kill)
- resp_valid  output  1  result available
- resp_ready  input  1  consumer takes result
- result  output  XLEN  product word or quotient/remainder
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset values (asynchronous, reset_n low): state IDLE, req_ready 1, resp_valid 0, result 0, busy 0, iteration counter 0. Reset mid-operation discards all work.
- States: IDLE, ITER, FIX, DONE.
- IDLE:
  - req_ready=1.
  - Accept on the edge where req_valid&&req_ready.
  - Latch the function.
  - Latch the operand magnitudes: a signed operand is negated if negative. MULHSU treats only op_a as signed.
  - Latch the result-negate flag.
  - Counter=0. Go to ITER.
- ITER:
  - 32 edges, counter 0..31.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract into 32-bit remainder and quotient.
  - Leave after the edge where counter==31, going to FIX.
- FIX, one edge:
  - Apply the sign to the result.
  - Select the word: MUL takes the low 32 bits; MULH/MULHSU/MULHU take the high 32 bits; DIV/DIVU the quotient; REM/REMU the remainder.
  - Register result. Go to DONE.
- Signs:
  - Quotient negated if dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - Product negated per the latched flag.
- DONE:
  - resp_valid=1; result held stable until handshake.
  - On resp_valid&&resp_ready → IDLE.
  - req_ready=0 in DONE; no overlap or bypass.
- Latency: accept edge E0, resp_valid high after edge E33. Back-to-back throughput is one op per 35 cycles minimum.
- Divide by zero: quotient 0xFFFFFFFF (both signed and unsigned); remainder = op_a. Divide iterations must produce these values naturally or they are forced in FIX.
- Signed overflow (DIV/REM with op_a 0x80000000, op_b 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- Negating 0x80000000 yields 0x80000000; magnitude paths are treated as unsigned 32-bit, so this is correct.
- flush:
  - In ITER/FIX/DONE: return to IDLE next edge and drop resp_valid.
  - In IDLE: no effect. flush wins over a simultaneous req_valid, i.e. no accept that cycle.
- result is not cleared on return to IDLE. It is valid only while resp_valid=1.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: in IDLE, a request is detected as early-out if any of these hold:
  - divide by zero;
  - signed overflow;
  - a multiply with either operand 0.
- An early-out request goes directly to DONE with the final result registered on the accept edge. resp_valid is high the cycle after accept.
- Undefined: all ops take the full 33-cycle latency with identical results.

Decomposition:
- Shared package muldiv_pkg:
  - muldiv_function encodings as constants (MD_MUL … MD_REMU);
  - state enum typedef (IDLE/ITER/FIX/DONE);
  - XLEN default;
  - DIV0_QUOTIENT constant 0xFFFFFFFF.
- One natural sub-module, muldiv_sign_fix: combinational conditional two's-complement negate plus word select. It is used for both operand magnitude and result fixup.

Test Plan:
- MUL 7×6 → result 0x0000002A; resp_valid exactly 33 cycles after the accept edge; busy high throughout.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0; MULHU with the same operands → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 0x80000000/0xFFFFFFFF → 0; overflow DIV 0x80000000/−1 → 0x80000000 with REM → 0.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5. With MULDIV_EARLY_OUT_EN, resp_valid is high 1 cycle after accept.
- Backpressure: hold resp_ready=0 for 10 cycles in DONE → result stable, req_ready=0, a new req_valid is not accepted; release → IDLE next edge.
- Assert flush at counter 15 → IDLE next edge with no resp_valid. Pulse reset_n low mid-ITER → all outputs at reset values immediately. A following MUL 3×3 → 9.
